// File: rtl/layer_sequencer_pkg.sv
// Shared types and defaults for the layer sequencer: layer kinds, FSM states,
// default table/watchdog sizes and the launch-pulse decode.
package layer_sequencer_pkg;

  localparam int unsigned MAX_LAYERS_DEF = 16;
  localparam int unsigned WDOG_W_DEF     = 24;

  typedef enum logic [1:0] {
    CONV   = 2'd0,
    POOL   = 2'd1,
    DENSE  = 2'd2,
    BYPASS = 2'd3
  } layer_type_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LAUNCH = 3'd2,
    WAIT   = 3'd3,
    SWAP   = 3'd4,
    FINISH = 3'd5
  } seq_state_e;

  // Launch pulse vector {dense, pool, conv} for a layer kind; BYPASS launches nothing.
  function automatic logic [2:0] start_vec(layer_type_e t);
    logic [2:0] v;
    v = 3'b000;
    case (t)
      CONV:    v = 3'b001;
      POOL:    v = 3'b010;
      DENSE:   v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/layer_sequencer_table.sv
// layer_table: MAX_LAYERS x 2-bit layer-kind register file, one synchronous
// write port, one combinational read port, async active-low clear.
module layer_table
  import layer_sequencer_pkg::*;
#(
  parameter int unsigned MAX_LAYERS = MAX_LAYERS_DEF,
  parameter int unsigned LIDX_W     = $clog2(MAX_LAYERS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [LIDX_W-1:0] waddr_i,
  input  layer_type_e       wdata_i,
  input  logic [LIDX_W-1:0] raddr_i,
  output layer_type_e       rdata_o
);

  layer_type_e mem_q [MAX_LAYERS];

  // Out-of-range addresses are silently dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(MAX_LAYERS); i++) begin
        mem_q[i] <= CONV;
      end
    end else if (we_i && (32'(waddr_i) < MAX_LAYERS)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/layer_sequencer.sv
// Layer sequencer: walks the programmed layer table, launches conv/pool/dense
// controllers one at a time and owns ping-pong + engine select.
// Optional WAIT watchdog enabled by defining LAYER_SEQ_WDOG_EN.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int unsigned MAX_LAYERS = MAX_LAYERS_DEF,
  parameter int unsigned LIDX_W     = $clog2(MAX_LAYERS),
  parameter int unsigned WDOG_W     = WDOG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LIDX_W:0]   num_layers,
  input  logic              cfg_we,
  input  logic [LIDX_W-1:0] cfg_addr,
  input  logic [1:0]        cfg_type,
  input  logic              conv_done,
  input  logic              pool_done,
  input  logic              dense_done,
  input  logic [WDOG_W-1:0] wdog_limit,
  output logic              conv_start,
  output logic              pool_start,
  output logic              dense_start,
  output logic [1:0]        engine_sel,
  output logic              aybz_azby,
  output logic [LIDX_W-1:0] layer_idx,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int unsigned     NUM_W   = LIDX_W + 1;
  localparam logic [NUM_W-1:0] MAX_NUM = NUM_W'(MAX_LAYERS);

  seq_state_e        state_q, state_d;
  layer_type_e       cur_q, cur_d, tbl_rd;
  logic [LIDX_W-1:0] idx_q, idx_d;
  logic [NUM_W-1:0]  num_q, num_d, num_clamp;
  logic              ay_q, ay_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [2:0]        st_q, st_d;
  logic              sel_done, last_layer, wdog_hit;

  // Table is kept out of the sequencer reset so a restart after reset reruns the last program.
  layer_table #(
    .MAX_LAYERS (MAX_LAYERS),
    .LIDX_W     (LIDX_W)
  ) u_table (
    .clk     (clk),
    .rst     (1'b1),
    .we_i    (cfg_we && !busy_q),
    .waddr_i (cfg_addr),
    .wdata_i (layer_type_e'(cfg_type)),
    .raddr_i (idx_q),
    .rdata_o (tbl_rd)
  );

  assign num_clamp  = (num_layers > MAX_NUM) ? MAX_NUM : num_layers;
  assign last_layer = ({1'b0, idx_q} == (num_q - NUM_W'(1)));

  always_comb begin
    sel_done = 1'b0;
    case (cur_q)
      CONV:    sel_done = conv_done;
      POOL:    sel_done = pool_done;
      DENSE:   sel_done = dense_done;
      default: sel_done = 1'b0;
    endcase
  end

`ifdef LAYER_SEQ_WDOG_EN
  logic [WDOG_W-1:0] wcnt_q, wcnt_d;
  logic              tmo_q, tmo_d;

  // Counter is held at zero outside WAIT, so it restarts on every WAIT entry.
  assign wcnt_d   = (state_q == WAIT) ? (wcnt_q + WDOG_W'(1)) : '0;
  assign wdog_hit = (wdog_limit != '0) && ((wcnt_q + WDOG_W'(1)) == wdog_limit);
  assign tmo_d    = (state_q == IDLE && start) ? 1'b0 :
                    ((state_q == WAIT && !sel_done && wdog_hit) ? 1'b1 : tmo_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      tmo_q  <= tmo_d;
    end
  end

  assign timeout = tmo_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^wdog_limit;
  assign wdog_hit    = 1'b0;
  assign timeout     = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    idx_d   = idx_q;
    num_d   = num_q;
    ay_d    = ay_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    st_d    = 3'b000;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_d = num_clamp;
          ay_d  = 1'b0;
          if (num_clamp == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
            idx_d   = '0;
            busy_d  = 1'b1;
          end
        end
      end
      FETCH: begin
        cur_d   = tbl_rd;
        st_d    = start_vec(tbl_rd);
        state_d = LAUNCH;
      end
      LAUNCH: begin
        state_d = (cur_q == BYPASS) ? SWAP : WAIT;
      end
      WAIT: begin
        if (sel_done) begin
          state_d = SWAP;
        end else if (wdog_hit) begin
          state_d = FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      SWAP: begin
        if (cur_q != BYPASS) begin
          ay_d = ~ay_q;
        end
        if (last_layer) begin
          state_d = FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          idx_d   = idx_q + LIDX_W'(1);
          state_d = FETCH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cur_q   <= CONV;
      idx_q   <= '0;
      num_q   <= '0;
      ay_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      st_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      ay_q    <= ay_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      st_q    <= st_d;
    end
  end

  assign conv_start  = st_q[0];
  assign pool_start  = st_q[1];
  assign dense_start = st_q[2];
  assign engine_sel  = cur_q;
  assign aybz_azby   = ay_q;
  assign layer_idx   = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
